// File: rtl/risc_seq_ctrl.sv
//------------------------------------------------------------------------------
// risc_seq_ctrl
//------------------------------------------------------------------------------
// Purpose:
//    Fetch/decode/execute sequencer for the simple RISC datapath. It fetches
//    8-bit instructions over a req/ack memory port, decodes them and drives
//    the ALU, the register-file selects and the immediate path.
//    Instruction byte: [7:4] opcode, [3:2] rd (operand A / destination),
//    [1:0] rs (operand B). LDI/JMP/JZ take a second byte (imm / address).
//
// Ports:
//    i_clk          clock, all state changes on posedge
//    i_rst_n        synchronous active-low reset
//    o_mem_addr     fetch address (always the current PC)
//    o_mem_rd       fetch request, held with a stable address until ack
//    i_mem_data     fetched byte, valid with i_mem_ack
//    i_mem_ack      fetch complete, data captured on this edge
//    o_alu_opcode   ALU opcode (IR[7:4] in EXEC, 0 otherwise)
//    o_alu_en       ALU compute enable
//    o_alu_oe       ALU output drive enable
//    i_zf_in        ALU zero flag, used by JZ
//    o_rf_sel_a     register-file read port A select
//    o_rf_sel_b     register-file read port B select
//    o_rf_we        register-file write enable
//    o_rf_wsel      register-file write select
//    o_rf_wsrc      write source: 0 = ALU bus, 1 = immediate
//    o_imm          immediate operand for LDI
//    o_pc           current program counter
//    o_halted       processor stopped
//    o_illegal      illegal opcode trapped
//
// Configuration:
//    RISC_ILLEGAL_TRAP_EN  when defined, an undefined opcode halts the core
//                          with o_illegal=1; when absent it executes as NOP
//                          and o_illegal stays 0.
//------------------------------------------------------------------------------
module risc_seq_ctrl #(
   parameter int PC_W = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic [PC_W-1:0] o_mem_addr,
   output logic            o_mem_rd,
   input  logic [7:0]      i_mem_data,
   input  logic            i_mem_ack,
   output logic [3:0]      o_alu_opcode,
   output logic            o_alu_en,
   output logic            o_alu_oe,
   input  logic            i_zf_in,
   output logic [1:0]      o_rf_sel_a,
   output logic [1:0]      o_rf_sel_b,
   output logic            o_rf_we,
   output logic [1:0]      o_rf_wsel,
   output logic            o_rf_wsrc,
   output logic [7:0]      o_imm,
   output logic [PC_W-1:0] o_pc,
   output logic            o_halted,
   output logic            o_illegal
);

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_HALT = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOTA = 4'b0111;
   localparam logic [3:0] OP_LDI  = 4'b1000;
   localparam logic [3:0] OP_JMP  = 4'b1001;
   localparam logic [3:0] OP_JZ   = 4'b1010;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_OPND,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [7:0]      r_ir;
   logic [7:0]      r_imm;
   logic            r_illegal;

   logic            r_mem_rd;
   logic [3:0]      r_alu_opcode;
   logic            r_alu_en;
   logic            r_alu_oe;
   logic [1:0]      r_rf_sel_a;
   logic [1:0]      r_rf_sel_b;
   logic            r_rf_we;
   logic [1:0]      r_rf_wsel;
   logic            r_rf_wsrc;
   logic            r_halted;

   state_t          w_state_nxt;
   logic [PC_W-1:0] w_pc_nxt;
   logic [7:0]      w_ir_nxt;
   logic [7:0]      w_imm_nxt;
   logic            w_illegal_nxt;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_target;
   logic [3:0]      w_op;
   logic [3:0]      w_op_nxt;
   logic            w_ack;

   logic            w_mem_rd_nxt;
   logic [3:0]      w_alu_opcode_nxt;
   logic            w_alu_en_nxt;
   logic            w_alu_oe_nxt;
   logic [1:0]      w_rf_sel_a_nxt;
   logic [1:0]      w_rf_sel_b_nxt;
   logic            w_rf_we_nxt;
   logic [1:0]      w_rf_wsel_nxt;
   logic            w_rf_wsrc_nxt;
   logic            w_halted_nxt;

   // An ack only counts while our own registered request is visible on the
   // port; this also covers the first cycle after reset, when the state is
   // already FETCH but the request has not been raised yet.
   assign w_ack    = i_mem_ack & r_mem_rd;
   assign w_pc_inc = r_pc + PC_W'(1);
   assign w_target = PC_W'(i_mem_data);
   assign w_op     = r_ir[7:4];
   assign w_op_nxt = w_ir_nxt[7:4];

   // Next-state logic plus the Moore outputs of the state being entered.
   // Outputs are computed from the next state and registered, so every
   // output is a flop and nothing flows combinationally from an input.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_ir_nxt      = r_ir;
      w_imm_nxt     = r_imm;
      w_illegal_nxt = r_illegal;

      case (r_state)
         S_FETCH: begin
            if (w_ack) begin
               w_ir_nxt    = i_mem_data;
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            case (w_op)
               OP_NOP:  w_state_nxt = S_FETCH;
               OP_HALT: w_state_nxt = S_HALT;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOTA:
                        w_state_nxt = S_EXEC;
               OP_LDI, OP_JMP, OP_JZ:
                        w_state_nxt = S_OPND;
               default: begin
`ifdef RISC_ILLEGAL_TRAP_EN
                  w_state_nxt   = S_HALT;
                  w_illegal_nxt = 1'b1;
`else
                  w_state_nxt   = S_FETCH;
`endif
               end
            endcase
         end
         S_OPND: begin
            if (w_ack) begin
               w_state_nxt = S_FETCH;
               case (w_op)
                  OP_LDI: begin
                     w_imm_nxt   = i_mem_data;
                     w_pc_nxt    = w_pc_inc;
                     w_state_nxt = S_WB;
                  end
                  OP_JMP:  w_pc_nxt = w_target;
                  default: w_pc_nxt = i_zf_in ? w_target : w_pc_inc;
               endcase
            end
         end
         S_EXEC:  w_state_nxt = S_WB;
         S_WB:    w_state_nxt = S_FETCH;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_FETCH;
      endcase

      w_mem_rd_nxt     = 1'b0;
      w_alu_opcode_nxt = 4'b0000;
      w_alu_en_nxt     = 1'b0;
      w_alu_oe_nxt     = 1'b0;
      w_rf_sel_a_nxt   = 2'b00;
      w_rf_sel_b_nxt   = 2'b00;
      w_rf_we_nxt      = 1'b0;
      w_rf_wsel_nxt    = 2'b00;
      w_rf_wsrc_nxt    = 1'b0;
      w_halted_nxt     = 1'b0;

      case (w_state_nxt)
         S_FETCH, S_OPND: w_mem_rd_nxt = 1'b1;
         S_EXEC: begin
            w_alu_en_nxt     = 1'b1;
            w_alu_opcode_nxt = w_op_nxt;
            w_rf_sel_a_nxt   = w_ir_nxt[3:2];
            w_rf_sel_b_nxt   = w_ir_nxt[1:0];
         end
         S_WB: begin
            w_rf_we_nxt   = 1'b1;
            w_rf_wsel_nxt = w_ir_nxt[3:2];
            if (w_op_nxt == OP_LDI) begin
               w_rf_wsrc_nxt = 1'b1;
            end else begin
               w_alu_oe_nxt  = 1'b1;
            end
         end
         S_HALT:  w_halted_nxt = 1'b1;
         default: w_mem_rd_nxt = 1'b0;
      endcase
   end

   // State, architectural registers and registered outputs. Reset clears
   // everything, which abandons any fetch handshake in flight.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_FETCH;
         r_pc         <= '0;
         r_ir         <= '0;
         r_imm        <= '0;
         r_illegal    <= 1'b0;
         r_mem_rd     <= 1'b0;
         r_alu_opcode <= 4'b0000;
         r_alu_en     <= 1'b0;
         r_alu_oe     <= 1'b0;
         r_rf_sel_a   <= 2'b00;
         r_rf_sel_b   <= 2'b00;
         r_rf_we      <= 1'b0;
         r_rf_wsel    <= 2'b00;
         r_rf_wsrc    <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_ir         <= w_ir_nxt;
         r_imm        <= w_imm_nxt;
         r_illegal    <= w_illegal_nxt;
         r_mem_rd     <= w_mem_rd_nxt;
         r_alu_opcode <= w_alu_opcode_nxt;
         r_alu_en     <= w_alu_en_nxt;
         r_alu_oe     <= w_alu_oe_nxt;
         r_rf_sel_a   <= w_rf_sel_a_nxt;
         r_rf_sel_b   <= w_rf_sel_b_nxt;
         r_rf_we      <= w_rf_we_nxt;
         r_rf_wsel    <= w_rf_wsel_nxt;
         r_rf_wsrc    <= w_rf_wsrc_nxt;
         r_halted     <= w_halted_nxt;
      end
   end

   assign o_mem_addr   = r_pc;
   assign o_pc         = r_pc;
   assign o_imm        = r_imm;
   assign o_illegal    = r_illegal;
   assign o_mem_rd     = r_mem_rd;
   assign o_alu_opcode = r_alu_opcode;
   assign o_alu_en     = r_alu_en;
   assign o_alu_oe     = r_alu_oe;
   assign o_rf_sel_a   = r_rf_sel_a;
   assign o_rf_sel_b   = r_rf_sel_b;
   assign o_rf_we      = r_rf_we;
   assign o_rf_wsel    = r_rf_wsel;
   assign o_rf_wsrc    = r_rf_wsrc;
   assign o_halted     = r_halted;

endmodule
